// File: rtl/concat_rep_scheduler.sv
// concat_rep_scheduler: round-robin shared {a,b}/{b,b} datapath for two requesters, valid/ready result.
// Defining CR_STATS_EN adds saturating per-requester completion counters on cnt0/cnt1.
module concat_rep_scheduler #(
    parameter int DW = 8
`ifdef CR_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    output logic            req1_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_cat,
    output logic [2*DW-1:0] out_rep,
    output logic            out_src,
`ifdef CR_STATS_EN
    output logic            busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`else
    output logic            busy
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            src_q, src_d;
    logic            last_grant_q, last_grant_d;
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] out_cat_q, out_cat_d, out_rep_q, out_rep_d;
    logic            out_src_q, out_src_d;
    logic            idle, grant1;

    always_comb begin
        idle = state_q == IDLE;
        // requester 1 wins alone, or on contention when requester 0 was served last
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
        req1_ready = idle & grant1;
        req0_ready = idle & req0_valid & ~grant1;
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        src_d = src_q;
        last_grant_d = last_grant_q;
        out_valid_d = out_valid_q;
        out_cat_d = out_cat_q;
        out_rep_d = out_rep_q;
        out_src_d = out_src_q;
        case (state_q)
            IDLE: if (req0_ready | req1_ready) begin
                a_d = grant1 ? req1_a : req0_a;
                b_d = grant1 ? req1_b : req0_b;
                src_d = grant1;
                last_grant_d = grant1;
                state_d = LOAD;
            end
            LOAD: state_d = EXEC;
            EXEC: begin
                out_cat_d = {a_q, b_q};
                out_rep_d = {2{b_q}};
                out_src_d = src_q;
                out_valid_d = 1'b1;
                state_d = HOLD;
            end
            default: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            src_q <= 1'b0;
            last_grant_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_cat_q <= '0;
            out_rep_q <= '0;
            out_src_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            src_q <= src_d;
            last_grant_q <= last_grant_d;
            out_valid_q <= out_valid_d;
            out_cat_q <= out_cat_d;
            out_rep_q <= out_rep_d;
            out_src_q <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cat = out_cat_q;
    assign out_rep = out_rep_q;
    assign out_src = out_src_q;
    assign busy = ~idle;

`ifdef CR_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             hs;

    always_comb begin
        hs = out_valid_q & out_ready;
        cnt0_d = (hs & ~out_src_q & ~&cnt0_q) ? cnt0_q + CNT_W'(1) : cnt0_q;
        cnt1_d = (hs & out_src_q & ~&cnt1_q) ? cnt1_q + CNT_W'(1) : cnt1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_concat_rep_scheduler.sv
// tb_concat_rep_scheduler: directed and random stimulus, transaction-level model with result scoreboard.
module tb_concat_rep_scheduler;
    localparam int DW = 8;
`ifdef CR_STATS_EN
    localparam int CNT_W = 4;
`endif

    typedef struct {
        logic [2*DW-1:0] cat;
        logic [2*DW-1:0] rep;
        logic            src;
        int              due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, out_valid, out_src, busy;
    logic [2*DW-1:0] out_cat, out_rep;
`ifdef CR_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc0 = -10, acc_cyc1 = -10;
    bit in_flight = 1'b0, last_m = 1'b1;
    int m_cnt0 = 0, m_cnt1 = 0;
    exp_t sb[$];
    bit grant_log[$];

    concat_rep_scheduler #(
        .DW(DW)
`ifdef CR_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cat(out_cat), .out_rep(out_rep), .out_src(out_src),
`ifdef CR_STATS_EN
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one transaction at a time, result visible 3 cycles after acceptance
    always @(negedge clk) begin
        bit e0, e1, ev;
        exp_t f;
        if (rst) begin
            in_flight = 1'b0;
            last_m = 1'b1;
            sb.delete();
            grant_log.delete();
            acc_cyc0 = -10;
            acc_cyc1 = -10;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            e0 = !in_flight && req0_valid && (!req1_valid || last_m);
            e1 = !in_flight && req1_valid && (!req0_valid || !last_m);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("busy", busy, in_flight);
`ifdef CR_STATS_EN
            chk("cnt0", cnt0, m_cnt0);
            chk("cnt1", cnt1, m_cnt1);
`endif
            ev = in_flight && sb.size() > 0 && cyc >= sb[0].due;
            chk("out_valid", out_valid, ev);
            if (ev) begin
                f = sb[0];
                chk("out_cat", out_cat, f.cat);
                chk("out_rep", out_rep, f.rep);
                chk("out_src", out_src, f.src);
                if (out_ready) begin
                    void'(sb.pop_front());
                    in_flight = 1'b0;
`ifdef CR_STATS_EN
                    if (f.src) m_cnt1 = m_cnt1 < (1 << CNT_W) - 1 ? m_cnt1 + 1 : m_cnt1;
                    else m_cnt0 = m_cnt0 < (1 << CNT_W) - 1 ? m_cnt0 + 1 : m_cnt0;
`endif
                end
            end
            if (e0 || e1) begin
                f.src = e1;
                f.cat = e1 ? {req1_a, req1_b} : {req0_a, req0_b};
                f.rep = e1 ? {req1_b, req1_b} : {req0_b, req0_b};
                f.due = cyc + 3;
                sb.push_back(f);
                in_flight = 1'b1;
                last_m = e1;
                grant_log.push_back(e1);
                if (e1) acc_cyc1 = cyc;
                else acc_cyc0 = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_acc(input bit r);
        for (int i = 0; i < 40; i++) begin
            tick;
            if ((r ? acc_cyc1 : acc_cyc0) == cyc - 1) return;
        end
        checks++;
        fails++;
        $display("FAIL accept_timeout: requester %0d not accepted within 40 cycles", r);
    endtask

    task automatic send(input bit r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        wait_acc(r);
        if (r) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [2*DW-1:0] cat, input logic [2*DW-1:0] rep, input bit src);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("dir_cat", out_cat, cat);
                chk("dir_rep", out_rep, rep);
                chk("dir_src", out_src, src);
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL result_timeout: out_valid not seen within 20 cycles");
    endtask

    task automatic rand_phase(input int n, input int p_ready);
        for (int i = 0; i < n; i++) begin
            if (acc_cyc0 == cyc - 1 || !req0_valid || $urandom_range(0, 15) == 0) begin
                req0_valid = $urandom_range(0, 2) != 0;
                req0_a = 8'($urandom);
                req0_b = 8'($urandom);
            end
            if (acc_cyc1 == cyc - 1 || !req1_valid || $urandom_range(0, 15) == 0) begin
                req1_valid = $urandom_range(0, 2) != 0;
                req1_a = 8'($urandom);
                req1_b = 8'($urandom);
            end
            out_ready = $urandom_range(0, 99) < p_ready;
            tick;
        end
    endtask

    initial begin
        logic [2*DW-1:0] held_cat;
        do_reset;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cat", out_cat, 0);
        chk("rst_out_rep", out_rep, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_busy", busy, 0);

        out_ready = 1'b1;
        send(0, 8'hFA, 8'h0F);
        wait_result(16'hFA0F, 16'h0F0F, 0);

        do_reset;
        out_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (acc_cyc0 == cyc - 1) begin req0_a = 8'($urandom); req0_b = 8'($urandom); end
            if (acc_cyc1 == cyc - 1) begin req1_a = 8'($urandom); req1_b = 8'($urandom); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("alt_count_ge8", grant_log.size() >= 8, 1);
        for (int i = 0; i < grant_log.size(); i++) chk("alt_grant", grant_log[i], i % 2);
        tick;
        tick;
        tick;
        tick;

        out_ready = 1'b0;
        send(0, 8'hC3, 8'h5A);
        req1_valid = 1'b1;
        req1_a = 8'h77;
        req1_b = 8'h88;
        wait_result(16'hC35A, 16'h5A5A, 0);
        held_cat = out_cat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_cat", out_cat, held_cat);
            chk("hold_busy", busy, 1);
            chk("hold_r0", req0_ready, 0);
            chk("hold_r1", req1_ready, 0);
        end
        tick;
        out_ready = 1'b1;
        wait_acc(1);
        req1_valid = 1'b0;
        wait_result(16'h7788, 16'h8888, 1);

        do_reset;
        out_ready = 1'b1;
        send(0, 8'h55, 8'hAA);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rstexec_valid", out_valid, 0);
        chk("rstexec_busy", busy, 0);
        send(1, 8'h12, 8'h34);
        wait_result(16'h1234, 16'h3434, 1);

`ifdef CR_STATS_EN
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(1, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 6; i++) tick;
        @(negedge clk);
        chk("sat_cnt1", cnt1, 4'hF);
        chk("sat_cnt0", cnt0, 0);
`endif

        do_reset;
        rand_phase(2000, 70);
        rand_phase(1000, 25);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
